// File: rtl/vec_cache_entry_alloc_arb.sv
// vec_cache_entry_alloc_arb
// Shares the vector-cache entry pool among REQ_NUM requesters. One free
// entry is kept pre-reserved in a slot so a grant can be issued every cycle;
// requesters are served round-robin and entries are reclaimed on release.
// Optional feature macro: VEC_CACHE_ALLOC_QUOTA_EN (per-requester hold limit).
module vec_cache_entry_alloc_arb #(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int REQ_NUM        = 4,
    parameter int QUOTA          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQ_NUM-1:0]        req_vld,
    output logic [REQ_NUM-1:0]        req_rdy,
    output logic [ENTRY_ID_WIDTH-1:0] alloc_id,
    input  logic                      rel_vld,
    input  logic [ENTRY_ID_WIDTH-1:0] rel_id,
    output logic [ENTRY_ID_WIDTH:0]   busy_cnt,
    output logic                      err_rel
);
    localparam int REQ_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = ENTRY_ID_WIDTH + 1;

    // Lowest clear bit of a busy vector; MSB of the result flags "found".
    function automatic logic [ENTRY_ID_WIDTH:0] f_lowest_free(input logic [ENTRY_NUM-1:0] busy);
        logic [ENTRY_ID_WIDTH:0] res;
        res = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                res = {1'b1, ENTRY_ID_WIDTH'(i)};
            end
        end
        return res;
    endfunction

    // Number of set bits in a busy vector.
    function automatic logic [CNT_W-1:0] f_popcount(input logic [ENTRY_NUM-1:0] v);
        logic [CNT_W-1:0] res;
        res = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            res = res + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return res;
    endfunction

    logic [ENTRY_NUM-1:0]      r_busy;
    logic                      r_slot_vld;
    logic [ENTRY_ID_WIDTH-1:0] r_slot_id;
    logic [REQ_W-1:0]          r_rr_ptr;
    logic                      r_err_rel;
    logic [CNT_W-1:0]          r_busy_cnt;

    logic [REQ_NUM-1:0]        w_elig;
    logic [2*REQ_NUM-1:0]      w_dbl;
    logic [REQ_W-1:0]          w_off;
    logic [REQ_W:0]            w_sum;
    logic [REQ_W:0]            w_sum_wrap;
    logic                      w_win_vld;
    logic [REQ_W-1:0]          w_win;
    logic [REQ_W-1:0]          w_rr_nxt;
    logic                      w_grant;
    logic                      w_rel_ok;
    logic                      w_rel_bad;
    logic [ENTRY_NUM-1:0]      w_busy_rel;
    logic [ENTRY_ID_WIDTH:0]   w_free;
    logic                      w_load;
    logic [ENTRY_NUM-1:0]      w_busy_nxt;

`ifdef VEC_CACHE_ALLOC_QUOTA_EN
    logic [CNT_W-1:0]          r_held  [REQ_NUM];
    logic [REQ_W-1:0]          r_owner [ENTRY_NUM];
    logic [REQ_W-1:0]          w_rel_owner;

    // A requester is eligible only while it holds fewer than QUOTA entries.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_elig[i] = req_vld[i] && (r_held[i] < CNT_W'(QUOTA));
        end
    end
`else
    // Without quota tracking every valid request is eligible.
    always_comb begin
        w_elig = req_vld;
    end
`endif

    // Round-robin pick: rotate eligibility so rr_ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        w_dbl     = {w_elig, w_elig} >> r_rr_ptr;
        w_off     = '0;
        w_win_vld = 1'b0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_off     = REQ_W'(k);
                w_win_vld = 1'b1;
            end
        end
        w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_sum_wrap = w_sum - (REQ_W+1)'(REQ_NUM);
        if (w_sum >= (REQ_W+1)'(REQ_NUM)) begin
            w_win = w_sum_wrap[REQ_W-1:0];
        end else begin
            w_win = w_sum[REQ_W-1:0];
        end
        if (w_win == REQ_W'(REQ_NUM - 1)) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = w_win + REQ_W'(1);
        end
        w_grant = r_slot_vld && w_win_vld;
    end

    // Release legality, busy-map update and slot refill from the post-release free map.
    always_comb begin
        w_rel_ok   = rel_vld && r_busy[rel_id] && !(r_slot_vld && (rel_id == r_slot_id));
        w_rel_bad  = rel_vld && !w_rel_ok;
        w_busy_rel = r_busy;
        if (w_rel_ok) begin
            w_busy_rel[rel_id] = 1'b0;
        end else begin
            w_busy_rel = r_busy;
        end
        w_free     = f_lowest_free(w_busy_rel);
        w_load     = (!r_slot_vld || w_grant) && w_free[ENTRY_ID_WIDTH];
        w_busy_nxt = w_busy_rel;
        if (w_load) begin
            w_busy_nxt[w_free[ENTRY_ID_WIDTH-1:0]] = 1'b1;
        end else begin
            w_busy_nxt = w_busy_rel;
        end
    end

    // One-hot grant is combinational so a waiting request is served with zero latency.
    always_comb begin
        req_rdy = '0;
        if (w_grant) begin
            req_rdy[w_win] = 1'b1;
        end else begin
            req_rdy = '0;
        end
    end

    assign alloc_id = r_slot_id;
    assign busy_cnt = r_busy_cnt;
    assign err_rel  = r_err_rel;

    // Pool state: busy map, reserved slot, round-robin pointer and sticky release error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_slot_vld <= 1'b0;
            r_slot_id  <= '0;
            r_rr_ptr   <= '0;
            r_err_rel  <= 1'b0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= f_popcount(w_busy_nxt);
            r_err_rel  <= r_err_rel | w_rel_bad;
            if (w_load) begin
                r_slot_vld <= 1'b1;
                r_slot_id  <= w_free[ENTRY_ID_WIDTH-1:0];
            end else if (w_grant) begin
                r_slot_vld <= 1'b0;
            end else begin
                r_slot_vld <= r_slot_vld;
            end
            if (w_grant) begin
                r_rr_ptr <= w_rr_nxt;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

`ifdef VEC_CACHE_ALLOC_QUOTA_EN
    assign w_rel_owner = r_owner[rel_id];

    // Ownership and per-requester hold counts; a same-requester grant+release nets to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                r_owner[e] <= '0;
            end
            for (int i = 0; i < REQ_NUM; i++) begin
                r_held[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_owner[r_slot_id] <= w_win;
            end
            for (int i = 0; i < REQ_NUM; i++) begin
                if (w_grant && (w_win == REQ_W'(i)) && !(w_rel_ok && (w_rel_owner == REQ_W'(i)))) begin
                    r_held[i] <= r_held[i] + CNT_W'(1);
                end else if (!(w_grant && (w_win == REQ_W'(i))) && w_rel_ok && (w_rel_owner == REQ_W'(i))) begin
                    r_held[i] <= r_held[i] - CNT_W'(1);
                end else begin
                    r_held[i] <= r_held[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vec_cache_entry_alloc_arb.sv
// Bench for vec_cache_entry_alloc_arb: directed scenarios followed by random
// traffic, all checked against a behavioural pool model kept in the bench.
module tb_vec_cache_entry_alloc_arb;
    localparam int EN    = 32;
    localparam int IDW   = 5;
    localparam int RN    = 4;
    localparam int TB_QUOTA = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [RN-1:0]  req_vld = '0;
    logic [RN-1:0]  req_rdy;
    logic [IDW-1:0] alloc_id;
    logic           rel_vld = 1'b0;
    logic [IDW-1:0] rel_id = '0;
    logic [IDW:0]   busy_cnt;
    logic           err_rel;

    vec_cache_entry_alloc_arb #(
        .ENTRY_NUM(EN), .ENTRY_ID_WIDTH(IDW), .REQ_NUM(RN), .QUOTA(TB_QUOTA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .alloc_id(alloc_id), .rel_vld(rel_vld), .rel_id(rel_id),
        .busy_cnt(busy_cnt), .err_rel(err_rel)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model of the pool
    bit m_busy  [EN];
    int m_owner [EN];
    bit m_slot_vld;
    int m_slot_id;
    int m_rr;
    int m_held  [RN];
    bit m_err;

    // Last values observed by cycle()
    logic [RN-1:0]  obs_rdy;
    logic [IDW-1:0] obs_id;
    logic [IDW:0]   obs_cnt;
    logic           obs_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int e = 0; e < EN; e++) c += int'(m_busy[e]);
        return c;
    endfunction

    function automatic bit quota_ok(input int r);
`ifdef VEC_CACHE_ALLOC_QUOTA_EN
        return m_held[r] < TB_QUOTA;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        for (int e = 0; e < EN; e++) begin m_busy[e] = 1'b0; m_owner[e] = 0; end
        for (int r = 0; r < RN; r++) m_held[r] = 0;
        m_slot_vld = 1'b0; m_slot_id = 0; m_rr = 0; m_err = 1'b0;
    endfunction

    // A releasable entry: busy and not the reserved slot; -1 if none
    function automatic int pick_legal();
        int start = int'($urandom_range(0, EN - 1));
        for (int j = 0; j < EN; j++) begin
            int id = (start + j) % EN;
            if (m_busy[id] && !(m_slot_vld && id == m_slot_id)) return id;
        end
        return -1;
    endfunction

    // Drive one cycle, compare outputs against the model, then advance the model over the edge.
    task automatic cycle(input logic [RN-1:0] rv, input bit relv, input int rid);
        int win;
        bit grant, legal;
        logic [RN-1:0] exp_rdy;
        int free;
        req_vld = rv; rel_vld = relv; rel_id = IDW'(rid);
        #2;
        win = -1;
        for (int k = 0; k < RN; k++) begin
            int idx = (m_rr + k) % RN;
            if (win < 0 && rv[idx] && quota_ok(idx)) win = idx;
        end
        grant   = m_slot_vld && (win >= 0);
        exp_rdy = grant ? RN'(1 << win) : '0;
        obs_rdy = req_rdy; obs_id = alloc_id; obs_cnt = busy_cnt; obs_err = err_rel;
        chk("req_rdy", req_rdy, exp_rdy);
        if (grant) chk("alloc_id", alloc_id, m_slot_id);
        chk("busy_cnt", busy_cnt, m_count());
        chk("err_rel", err_rel, m_err);
        legal = relv && m_busy[rid] && !(m_slot_vld && rid == m_slot_id);
        if (relv && !legal) m_err = 1'b1;
        if (legal) begin m_busy[rid] = 1'b0; m_held[m_owner[rid]]--; end
        if (grant) begin
            m_owner[m_slot_id] = win; m_held[win]++; m_rr = (win + 1) % RN;
        end
        if (!m_slot_vld || grant) begin
            free = -1;
            for (int e = EN - 1; e >= 0; e--) if (!m_busy[e]) free = e;
            if (free >= 0) begin m_slot_vld = 1'b1; m_slot_id = free; m_busy[free] = 1'b1; end
            else m_slot_vld = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Assert reset, check outputs drop immediately, release and let the slot fill.
    task automatic do_reset();
        rst_n = 1'b0; req_vld = '0; rel_vld = 1'b0; rel_id = '0;
        #2;
        chk("rst_busy_cnt", busy_cnt, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_err_rel", err_rel, 0);
        chk("rst_alloc_id", alloc_id, 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        cycle('0, 1'b0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, rid, saved_id, saved_cnt;
        bit relv;
        #1;
        // Single requester: consecutive IDs from cycle 1
        do_reset();
        cycle(4'b0001, 1'b0, 0);
        chk("first_grant_id", obs_id, 0);
        chk("first_grant_rdy", obs_rdy, 4'b0001);
        repeat (5) cycle(4'b0001, 1'b0, 0);
        chk("seq_id5", obs_id, 5);
        // All requesting: rotation
        repeat (8) cycle(4'b1111, 1'b0, 0);
        // Fill the pool
        guard = 0;
        while (!(m_count() == EN && !m_slot_vld) && guard < 60) begin
            cycle(4'b1111, 1'b0, 0); guard++;
        end
        chk("fill_in_budget", 32'(guard < 60), 1);
        cycle(4'b1111, 1'b1, 7);
        chk("exhaust_rdy", obs_rdy, 0);
        cycle(4'b1111, 1'b0, 0);
        chk("rel7_granted", 32'(obs_rdy != '0), 1);
        chk("rel7_id", obs_id, 7);

        // Quota scenario
        do_reset();
        repeat (10) cycle(4'b0001, 1'b0, 0);
`ifdef VEC_CACHE_ALLOC_QUOTA_EN
        chk("quota_block", obs_rdy, 4'b0000);
`else
        chk("no_quota_grant", obs_rdy, 4'b0001);
`endif
        cycle(4'b0011, 1'b0, 0);
        chk("quota_other", obs_rdy, 4'b0010);
        cycle(4'b0001, 1'b1, 0);
        cycle(4'b0001, 1'b0, 0);
        chk("quota_regrant", obs_rdy, 4'b0001);

        // Illegal releases: never-granted ID, then the reserved slot
        saved_cnt = m_count();
        cycle(4'b0000, 1'b1, 25);
        saved_id = m_slot_id;
        cycle(4'b0000, 1'b1, saved_id);
        chk("err_after_bad", obs_err, 1);
        cycle(4'b0100, 1'b0, 0);
        chk("bad_rel_cnt", obs_cnt, saved_cnt);
        chk("slot_kept", obs_id, saved_id);
        chk("err_sticky", obs_err, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            relv = ($urandom_range(0, 2) == 0);
            rid  = pick_legal();
            if ($urandom_range(0, 9) == 0) rid = int'($urandom_range(0, EN - 1));
            if (rid < 0) begin relv = 1'b0; rid = 0; end
            cycle(RN'($urandom), relv, rid);
        end

        // Mid-operation reset with 10+ entries busy
        do_reset();
        repeat (10) cycle(4'b1111, 1'b0, 0);
        chk("pre_reset_busy", busy_cnt, 11);
        do_reset();
        cycle(4'b0001, 1'b0, 0);
        chk("post_reset_id", obs_id, 0);
        chk("post_reset_rdy", obs_rdy, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
